// File: rtl/output_port_fifo.sv
// Output-port FIFO capturing the micro o_reg on each o_reg_load, first-word-fall-through read side.
// Optional OPORT_DROP_REPEAT_EN suppresses pushes that repeat the last accepted value.
module output_port_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         o_reg,
    input  logic                     o_reg_load,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             load_d;
    logic             ovf;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign count    = cnt;
    assign overflow = ovf;
    assign m_valid  = !empty;
    assign m_data   = empty ? '0 : mem[rd_ptr];
    assign pop      = m_valid && m_ready;

`ifdef OPORT_DROP_REPEAT_EN
    logic [WIDTH-1:0] last_val;
    logic             last_vld;

    // A repeat is neither stored nor treated as an overflow drop.
    assign push_req = load_d && !(last_vld && (o_reg == last_val));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_val <= '0;
            last_vld <= 1'b0;
        end else if (push_ok) begin
            last_val <= o_reg;
            last_vld <= 1'b1;
        end
    end
`else
    assign push_req = load_d;
`endif

    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= o_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            load_d <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            load_d <= o_reg_load;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_port_fifo.sv
// Directed self-checking bench for output_port_fifo (DEPTH=8, WIDTH=4).
// Emulates the micro o_reg register: the value appears on o_reg just after the load edge.
module tb_output_port_fifo;

    logic       clk;
    logic       rst_n;
    logic [3:0] o_reg;
    logic       o_reg_load;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;

    int checks   = 0;
    int failures = 0;

    output_port_fifo #(.DEPTH(8), .WIDTH(4)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .o_reg      (o_reg),
        .o_reg_load (o_reg_load),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back loads of n nibbles from vals (entry i at vals[4*i +: 4]); ends after the last push edge.
    task automatic load_seq(input int unsigned n, input logic [63:0] vals);
        for (int unsigned i = 0; i < n; i++) begin
            o_reg_load = 1'b1;
            tick();
            o_reg = vals[4*i +: 4];
        end
        o_reg_load = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; o_reg = '0; o_reg_load = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        checks++; if (m_valid !== 1'b0)  begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 4'h0)   begin failures++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
        checks++; if (count !== 4'd0)    begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (full !== 1'b0)     begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        o_reg_load = 1'b1;
        tick();
        o_reg = 4'h5; o_reg_load = 1'b0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_edge1 got=%b exp=0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid_edge2 got=%b exp=1", m_valid); end
        checks++; if (m_data !== 4'h5)  begin failures++; $display("FAIL single_data got=%h exp=5", m_data); end
        checks++; if (count !== 4'd1)   begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        checks++; if (m_data !== 4'h0)  begin failures++; $display("FAIL single_pop_data got=%h exp=0", m_data); end
    endtask

    task automatic test_fill_overflow();
        logic [3:0] exp;
        load_seq(9, 64'h0000_0009_8765_4321);
        checks++; if (full !== 1'b1)     begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 4'd8)    begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        for (int unsigned i = 1; i <= 8; i++) begin
            exp = 4'(i);
            checks++; if (m_data !== exp) begin failures++; $display("FAIL fill_drain_%0d got=%h exp=%h", i, m_data, exp); end
            m_ready = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_push_pop();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        load_seq(8, 64'h8765_4321);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fpp_prefill_count got=%0d exp=8", count); end
        o_reg_load = 1'b1;
        tick();
        o_reg = 4'hA; o_reg_load = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (count !== 4'd8)    begin failures++; $display("FAIL fpp_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
        checks++; if (m_data !== 4'h2)   begin failures++; $display("FAIL fpp_head got=%h exp=2", m_data); end
    endtask

    task automatic test_overflow_clear();
        logic [3:0] exp;
        o_reg_load = 1'b1;
        tick();
        o_reg = 4'hC; o_reg_load = 1'b0;
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovc_drop got=%b exp=1", overflow); end
        o_reg_load = 1'b1;
        tick();
        o_reg = 4'hD; o_reg_load = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovc_set_wins got=%b exp=1", overflow); end
        checks++; if (count !== 4'd8)    begin failures++; $display("FAIL ovc_count got=%0d exp=8", count); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovc_clear got=%b exp=0", overflow); end
        for (int unsigned i = 0; i < 8; i++) begin
            exp = (i == 7) ? 4'hA : 4'(i + 2);
            checks++; if (m_data !== exp) begin failures++; $display("FAIL wrap_drain_%0d got=%h exp=%h", i, m_data, exp); end
            m_ready = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_async_reset();
        load_seq(3, 64'h0000_0000_0000_0321);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL ares_prefill got=%0d exp=3", count); end
        o_reg_load = 1'b1;
        tick();
        o_reg = 4'h7; o_reg_load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0)   begin failures++; $display("FAIL ares_count got=%0d exp=0", count); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ares_valid got=%b exp=0", m_valid); end
        #1 rst_n = 1'b1;
        tick();
        checks++; if (count !== 4'd0)   begin failures++; $display("FAIL ares_pending got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL ares_empty got=%b exp=1", empty); end
    endtask

    task automatic test_repeat();
        logic [3:0] exp_q [$];
        load_seq(4, 64'h0000_0000_0000_3433);
`ifdef OPORT_DROP_REPEAT_EN
        exp_q = '{4'h3, 4'h4, 4'h3};
`else
        exp_q = '{4'h3, 4'h3, 4'h4, 4'h3};
`endif
        checks++; if (count !== 4'(exp_q.size())) begin failures++; $display("FAIL rep_count got=%0d exp=%0d", count, exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rep_overflow got=%b exp=0", overflow); end
        foreach (exp_q[i]) begin
            checks++; if (m_data !== exp_q[i]) begin failures++; $display("FAIL rep_drain_%0d got=%h exp=%h", i, m_data, exp_q[i]); end
            m_ready = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rep_empty got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_overflow_clear();
        test_async_reset();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/output_port_fifo.md
OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

Interface
REQ-001 Parameter DEPTH, default 8; FIFO entries, power of two, 2..64.
REQ-002 Parameter WIDTH, default 4; entry width, equals micro o_reg width.
REQ-003 The block SHALL provide these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- o_reg  input  WIDTH  micro output register value.
- o_reg_load  input  1  micro o_reg load enable, register_enables[8]; o_reg takes its new value at the same edge this is sampled high.
- m_data  output  WIDTH  head entry.
- m_valid  output  1  head entry present.
- m_ready  input  1  consumer accepts the head entry.
- count  output  log2(DEPTH)+1  entries held.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a push was dropped.
- clr_ovf  input  1  clears overflow.

Function
REQ-004 Capture: the block SHALL register o_reg_load into load_d; push request = load_d, push data = o_reg sampled at the same edge.
REQ-005 Latency: o_reg_load high before edge N -> entry written at edge N+1 -> m_valid high after edge N+1 when previously empty.
REQ-006 Pop = m_valid AND m_ready; the head advances at that edge; m_data/m_valid SHALL be registered-state outputs (first-word-fall-through, no combinational path from m_ready).
REQ-007 m_valid SHALL equal NOT empty; m_data SHALL be 0 while empty.
REQ-008 Push accepted when NOT full, or when full with a pop in the same cycle.
REQ-009 Push while full without pop SHALL be dropped, contents unchanged, overflow set at that edge.
REQ-010 Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
REQ-011 Push while empty: no pop is possible that cycle; the entry appears at the head after the edge.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-013 clr_ovf high clears overflow at the edge; a drop in the same cycle SHALL leave overflow at 1 (set wins).
REQ-014 Back-to-back o_reg_load on consecutive cycles SHALL push one entry per cycle, in order.
REQ-015 Internal state: a pointer-based FIFO of DEPTH x WIDTH, with no state machine beyond the pointers, counter and flags.

Reset
REQ-016 While reset is low: read and write pointers, count, load_d, the overflow flag and the last-pushed register SHALL be 0.
REQ-017 Reset outputs: m_valid 0, m_data 0, count 0, full 0, empty 1, overflow 0.
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge, including a push pending in load_d.
REQ-019 Storage array contents need not be reset.

Configuration
REQ-020 Macro OPORT_DROP_REPEAT_EN.
- Defined: the block holds a last-pushed value register (valid flag cleared by reset). A push whose data equals the last accepted value SHALL be suppressed; it is neither stored nor counted as overflow.
- Undefined: every load_d push is processed, and the last-pushed register is not built.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then o_reg=0x5 with o_reg_load for 1 cycle -> m_valid rises after the 2nd edge, m_data=0x5, count=1; with m_ready=1 for 1 cycle -> empty=1, m_data=0.
- m_ready=0 and 9 consecutive loads of values 0x1..0x9 (DEPTH=8) -> full=1, count=8, overflow=1; drain yields 0x1..0x8 in order.
- Full FIFO, push 0xA with m_ready=1 in the same cycle -> count stays 8 and overflow stays 0; 0xA is drained last.
- overflow=1, then clr_ovf together with a further dropped push -> overflow=1; clr_ovf alone on a later cycle -> overflow=0.
- 3 entries stored, reset pulsed low mid-cycle -> count=0, m_valid=0 before the next edge; a load pending in load_d is not stored.
- With OPORT_DROP_REPEAT_EN, loads 0x3, 0x3, 0x4, 0x3 -> stored entries 0x3, 0x4, 0x3 (count=3); without the macro -> count=4.
